// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing the register file's single write port among NREQ sources.
// Define REGWB_ARB_RR_EN for round-robin priority; otherwise the lowest index wins.
module regfile_wb_arbiter #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clock,
   input  logic                 ctrl_reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [5*NREQ-1:0]    req_reg,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 stall,
   output logic                 ctrl_writeEnable,
   output logic [4:0]           ctrl_writeReg,
   output logic [31:0]          data_writeReg,
   output logic [CNT_W-1:0]     contention_count
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [NREQ-1:0]  grant;
   logic             xfer;
   logic [PW-1:0]    sel;
   int               idx;
   logic [4:0]       wreg;
   logic [31:0]      wdata;
   logic             lose;
`ifdef REGWB_ARB_RR_EN
   logic [PW-1:0]    gidx;
`endif

   logic             we_q, we_d;
   logic [4:0]       reg_q, reg_d;
   logic [31:0]      data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Search starts at ptr and wraps; first valid requester wins.
   always_comb begin
      grant = '0;
      xfer  = 1'b0;
      idx   = 0;
      sel   = '0;
`ifdef REGWB_ARB_RR_EN
      gidx  = '0;
`endif
      if (!ctrl_reset && !stall) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = PW'(idx);
            if (!xfer && req_valid[sel]) begin
               xfer       = 1'b1;
               grant[sel] = 1'b1;
`ifdef REGWB_ARB_RR_EN
               gidx       = sel;
`endif
            end
         end
      end
   end

   always_comb begin
      wreg  = '0;
      wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            wreg  = req_reg[5*i +: 5];
            wdata = req_data[32*i +: 32];
         end
      end
   end

   always_comb begin
      we_d   = xfer && (wreg != 5'd0);
      reg_d  = xfer ? wreg  : reg_q;
      data_d = xfer ? wdata : data_q;
`ifdef REGWB_ARB_RR_EN
      ptr_d  = ptr_q;
      if (xfer) ptr_d = (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
`else
      ptr_d  = '0;
`endif
      lose   = |(req_valid & ~grant);
      cnt_d  = (lose && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         we_q   <= 1'b0;
         reg_q  <= '0;
         data_q <= '0;
         ptr_q  <= '0;
         cnt_q  <= '0;
      end else begin
         we_q   <= we_d;
         reg_q  <= reg_d;
         data_q <= data_d;
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign req_ready        = grant;
   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = reg_q;
   assign data_writeReg    = data_q;
   assign contention_count = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: random and directed traffic checked
// against a cycle-level reference model of the grant rules.
module tb_regfile_wb_arbiter;

   localparam int NREQ  = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic                clock = 1'b0;
   logic                ctrl_reset = 1'b1;
   logic                stall = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [5*NREQ-1:0]   req_reg = '0;
   logic [32*NREQ-1:0]  req_data = '0;
   logic [NREQ-1:0]     req_ready;
   logic                ctrl_writeEnable;
   logic [4:0]          ctrl_writeReg;
   logic [31:0]         data_writeReg;
   logic [CNT_W-1:0]    contention_count;

   always #5 clock = ~clock;

   regfile_wb_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .req_valid        (req_valid),
      .req_reg          (req_reg),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .stall            (stall),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .contention_count (contention_count)
   );

   typedef struct packed {
      logic             we;
      logic [4:0]       wr;
      logic [31:0]      wd;
      logic [CNT_W-1:0] cnt;
   } out_t;

   logic [NREQ-1:0] q_rdy[$];
   out_t            q_out[$];
   int checks = 0;
   int errors = 0;

   logic        cur_v[NREQ];
   logic [4:0]  cur_r[NREQ];
   logic [31:0] cur_d[NREQ];

   int          m_ptr = 0;
   int          m_cnt = 0;
   logic        m_we = 1'b0;
   logic [4:0]  m_reg = '0;
   logic [31:0] m_data = '0;

   function automatic logic [4:0] rnd_reg();
      logic [4:0] r;
      r = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) r = '0;
      return r;
   endfunction

   task automatic renew(input int i, input bit v);
      cur_v[i] = v;
      cur_r[i] = rnd_reg();
      cur_d[i] = $urandom();
   endtask

   // Drive one cycle, advance the model, queue what the DUT must show.
   task automatic cycle(input logic rst, input logic stl, output int g);
      logic [NREQ-1:0] er;
      bit   lose;
      out_t o;
      int   i;
      @(negedge clock);
      ctrl_reset = rst;
      stall      = stl;
      for (int k = 0; k < NREQ; k++) begin
         req_valid[k]         = cur_v[k];
         req_reg[5*k +: 5]    = cur_r[k];
         req_data[32*k +: 32] = cur_d[k];
      end
      g = -1;
      if (!rst && !stl) begin
         for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (g < 0 && cur_v[i]) g = i;
         end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      lose = 1'b0;
      for (int k = 0; k < NREQ; k++)
         if (cur_v[k] && k != g) lose = 1'b1;
      if (rst) begin
         m_we = 1'b0; m_reg = '0; m_data = '0; m_ptr = 0; m_cnt = 0;
      end else begin
         if (g >= 0) begin
            m_we   = (cur_r[g] != 5'd0);
            m_reg  = cur_r[g];
            m_data = cur_d[g];
`ifdef REGWB_ARB_RR_EN
            m_ptr  = (g + 1) % NREQ;
`endif
         end else begin
            m_we = 1'b0;
         end
         if (lose && m_cnt < CMAX) m_cnt = m_cnt + 1;
      end
      o.we  = m_we;
      o.wr  = m_reg;
      o.wd  = m_data;
      o.cnt = m_cnt[CNT_W-1:0];
      q_rdy.push_back(er);
      q_out.push_back(o);
   endtask

   initial begin : monitor
      logic [NREQ-1:0] e;
      out_t o;
      forever begin
         @(negedge clock);
         #2;
         if (q_rdy.size() > 0) begin
            e = q_rdy.pop_front();
            checks++;
            if (req_ready !== e) begin
               errors++;
               $display("FAIL req_ready: got %b expected %b @%0t", req_ready, e, $time);
            end
         end
         @(posedge clock);
         #1;
         if (q_out.size() > 0) begin
            o = q_out.pop_front();
            checks++;
            if (ctrl_writeEnable !== o.we) begin
               errors++;
               $display("FAIL writeEnable: got %b expected %b @%0t", ctrl_writeEnable, o.we, $time);
            end
            checks++;
            if (ctrl_writeReg !== o.wr) begin
               errors++;
               $display("FAIL writeReg: got %0d expected %0d @%0t", ctrl_writeReg, o.wr, $time);
            end
            checks++;
            if (data_writeReg !== o.wd) begin
               errors++;
               $display("FAIL writeData: got %h expected %h @%0t", data_writeReg, o.wd, $time);
            end
            checks++;
            if (contention_count !== o.cnt) begin
               errors++;
               $display("FAIL contention: got %0d expected %0d @%0t", contention_count, o.cnt, $time);
            end
         end
      end
   end

   initial begin : stim
      int g;
      int n;
      logic rst;
      logic stl;
      for (int i = 0; i < NREQ; i++) renew(i, 1'b1);
      // Reset with every requester asking.
      cycle(1'b1, 1'b0, g);
      cycle(1'b1, 1'b0, g);
      // Continuous contention straight out of reset.
      repeat (5) begin
         cycle(1'b0, 1'b0, g);
         if (g >= 0) renew(g, 1'b1);
      end
      for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
      cycle(1'b0, 1'b0, g);
      // Single write, then an r0 write that must be dropped.
      cur_v[0] = 1'b1; cur_r[0] = 5'd5; cur_d[0] = 32'hDEADBEEF;
      cycle(1'b0, 1'b0, g);
      cur_v[0] = 1'b0;
      cycle(1'b0, 1'b0, g);
      cur_v[2] = 1'b1; cur_r[2] = 5'd0; cur_d[2] = 32'h12345678;
      cycle(1'b0, 1'b0, g);
      cur_v[2] = 1'b0;
      cycle(1'b0, 1'b0, g);
      // Stall holds off requester 1 for three cycles.
      cur_v[1] = 1'b1; cur_r[1] = 5'd9; cur_d[1] = 32'hCAFEF00D;
      repeat (3) cycle(1'b0, 1'b1, g);
      cycle(1'b0, 1'b0, g);
      if (g >= 0) cur_v[g] = 1'b0;
      cycle(1'b0, 1'b0, g);
      // Reset while a transfer would happen.
      for (int i = 0; i < NREQ; i++) renew(i, 1'b1);
      cycle(1'b0, 1'b0, g);
      if (g >= 0) renew(g, 1'b1);
      cycle(1'b1, 1'b0, g);
      cycle(1'b0, 1'b0, g);
      if (g >= 0) renew(g, 1'b1);
      // Drive the counter into saturation.
      repeat (20) cycle(1'b0, 1'b1, g);
      // Random traffic.
      repeat (400) begin
         rst = ($urandom_range(0, 49) == 0);
         stl = ($urandom_range(0, 4) == 0);
         cycle(rst, stl, g);
         if (g >= 0) renew(g, 1'($urandom_range(0, 1)));
         for (int i = 0; i < NREQ; i++)
            if (!cur_v[i] && $urandom_range(0, 2) == 0) renew(i, 1'b1);
      end
      for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
      cycle(1'b0, 1'b0, g);
      cycle(1'b0, 1'b0, g);
      n = 0;
      while ((q_rdy.size() > 0 || q_out.size() > 0) && n < 10) begin
         @(posedge clock);
         #2;
         n++;
      end
      if (q_rdy.size() > 0 || q_out.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", q_rdy.size(), q_out.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
